ring_fifo: RTL and testbench

Parametrised synchronous circular-buffer FIFO for the coder datapath. It replaces shift-register buffering with read/write pointers and an occupancy counter. Features:
- true DEPTH-entry capacity, including non-power-of-2 depths
- simultaneous read and write
- selectable show-ahead or registered read port
- almost-full/almost-empty thresholds
- sticky overflow/underflow flags
Sits between coder pipeline stages wherever bursty producers meet stalling consumers.

---
 rtl/ring_fifo_pkg.sv | 20 ++
 rtl/ring_fifo_if.sv | 35 +++
 rtl/ring_fifo_ptr_wrap.sv | 32 +++
 rtl/ring_fifo.sv | 115 +++++++++++
 tb/tb_ring_fifo.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ring_fifo_pkg.sv
// Shared types and elaboration helpers for the coder-datapath ring FIFO.
// Pointer/count widths are derived here so the interface and RTL agree.
package coder_fifo_pkg;

  typedef enum logic {FIFO_REGISTERED = 1'b0, FIFO_SHOWAHEAD = 1'b1} fifo_mode_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit fifo_cfg_ok(input int depth, input int af_level, input int ae_level);
    return (depth >= 2) && (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/ring_fifo_if.sv
// Producer/consumer handshake bundle for ring_fifo; master is the user side,
// slave is the FIFO itself.
interface ring_fifo_if
  import coder_fifo_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 5
);
  localparam int CW = count_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/ring_fifo_ptr_wrap.sv
// Modulo-DEPTH pointer: counts 0..DEPTH-1 and wraps, so non-power-of-2
// depths use every slot.
module fifo_ptr_wrap
  import coder_fifo_pkg::*;
#(
  parameter  int DEPTH = 5,
  localparam int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (rst) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with occupancy counter, thresholds, sticky error flags
// and a selectable show-ahead or registered read port.
module ring_fifo
  import coder_fifo_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DEPTH    = 5,
  parameter int FWFT     = 1,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst,
  ring_fifo_if.slave  bus
);
  localparam int         CW   = count_width(DEPTH);
  localparam int         PW   = ptr_width(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_SHOWAHEAD : FIFO_REGISTERED;

  if (!fifo_cfg_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
    $error("ring_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL configuration");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             empty, full, rd_acc, wr_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign rd_acc = bus.rd_en & ~empty;
  // A write while full only fits because the same-cycle read frees a slot.
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .rst(rst), .inc(wr_acc), .ptr(wr_ptr)
  );
  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .rst(rst), .inc(rd_acc), .ptr(rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr] <= bus.wr_data;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (rst) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
      if (bus.wr_en && !wr_acc)   ovf_d = 1'b1;
      if (bus.rd_en && empty)     udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  if (MODE == FIFO_SHOWAHEAD) begin : g_showahead
    assign bus.rd_data  = mem_q[rd_ptr];
    assign bus.rd_valid = ~empty;
  end else begin : g_registered
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (rst) begin
        rdata_d = '0;
      end else if (rd_acc) begin
        rdata_d  = mem_q[rd_ptr];
        rvalid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.rd_data  = rdata_q;
    assign bus.rd_valid = rvalid_q;
  end
endmodule

// File: tb/tb_ring_fifo.sv
// Drives a show-ahead and a registered ring_fifo with identical stimulus and
// checks both against a queue-based reference model.
module tb_ring_fifo;
  localparam int W = 10;
  localparam int D = 5;

  logic clk, rst_n, rst;
  int   vectors = 0;
  int   miscompares = 0;

  ring_fifo_if #(.WIDTH(W), .DEPTH(D)) f1 ();
  ring_fifo_if #(.WIDTH(W), .DEPTH(D)) f0 ();

  ring_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut_sa (
    .clk(clk), .rst_n(rst_n), .rst(rst), .bus(f1)
  );
  ring_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut_rg (
    .clk(clk), .rst_n(rst_n), .rst(rst), .bus(f0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [W-1:0] q[$];
  bit           m_ovf, m_udf, m_rv;
  logic [W-1:0] m_rdat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_udf  = 0;
    m_rv   = 0;
    m_rdat = '0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count_sa",  32'(f1.count), 32'(n));
    chk("count_rg",  32'(f0.count), 32'(n));
    chk("empty",     32'(f1.empty), 32'(n == 0));
    chk("full",      32'(f1.full),  32'(n == D));
    chk("almost_full",  32'(f1.almost_full),  32'(n >= D - 1));
    chk("almost_empty", 32'(f1.almost_empty), 32'(n <= 1));
    chk("overflow_sa",  32'(f1.overflow),  32'(m_ovf));
    chk("underflow_sa", 32'(f1.underflow), 32'(m_udf));
    chk("overflow_rg",  32'(f0.overflow),  32'(m_ovf));
    chk("underflow_rg", 32'(f0.underflow), 32'(m_udf));
    chk("rd_valid_sa",  32'(f1.rd_valid),  32'(n != 0));
    chk("rd_valid_rg",  32'(f0.rd_valid),  32'(m_rv));
    chk("rd_data_rg",   32'(f0.rd_data),   32'(m_rdat));
    if (n != 0) chk("rd_data_sa", 32'(f1.rd_data), 32'(q[0]));
  endtask

  // One clock of identical stimulus to both DUTs, model update, then checks.
  task automatic step(input bit wr, input logic [W-1:0] wd, input bit rd, input bit flush = 0);
    bit ra, wa;
    f1.wr_en = wr; f1.wr_data = wd; f1.rd_en = rd;
    f0.wr_en = wr; f0.wr_data = wd; f0.rd_en = rd;
    rst = flush;
    #1;
    if (q.size() != 0) chk("head_pre_edge", 32'(f1.rd_data), 32'(q[0]));
    @(posedge clk);
    if (flush) begin
      model_reset();
    end else begin
      ra = rd && (q.size() > 0);
      wa = wr && ((q.size() < D) || ra);
      if (wr && !wa) m_ovf = 1;
      if (rd && q.size() == 0) m_udf = 1;
      m_rv = ra;
      if (ra) m_rdat = q.pop_front();
      if (wa) q.push_back(wd);
    end
    #1;
    rst = 1'b0;
    f1.wr_en = 0; f1.rd_en = 0; f0.wr_en = 0; f0.rd_en = 0;
    check_all();
  endtask

  initial begin
    bit wr, rd;
    rst_n = 1'b0;
    rst   = 1'b0;
    f1.wr_en = 0; f1.rd_en = 0; f1.wr_data = '0;
    f0.wr_en = 0; f0.rd_en = 0; f0.wr_data = '0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // fill then drain
    for (int i = 1; i <= D; i++) step(1, W'(i), 0);
    for (int i = 0; i < D; i++) step(0, '0, 1);

    // overflow, underflow, flush
    for (int i = 1; i <= D; i++) step(1, W'(i), 0);
    step(1, 10'h3FF, 0);
    step(0, '0, 0);
    for (int i = 0; i < D; i++) step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0, 1);

    // simultaneous read+write at full and at empty
    for (int i = 0; i < D; i++) step(1, W'(10'h050 + i), 0);
    for (int i = 0; i < 10; i++) step(1, W'(10'h100 + i), 1);
    for (int i = 0; i < D; i++) step(0, '0, 1);
    step(1, 10'h2A5, 1);
    step(1, 10'h0F0, 1, 1);

    // random traffic keeping occupancy in 1..4
    step(1, W'($urandom), 0);
    step(1, W'($urandom), 0);
    for (int i = 0; i < 23; i++) begin
      wr = ($urandom_range(7) != 0);
      rd = ($urandom_range(7) != 0);
      if (q.size() >= D - 1 && wr && !rd) rd = 1;
      if (q.size() <= 1 && rd && !wr) wr = 1;
      step(wr, W'($urandom), rd);
    end

    // registered-port timing
    while (q.size() != 0) step(0, '0, 1);
    step(1, 10'h0AA, 0);
    step(1, 10'h0BB, 0);
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 0);
    step(0, '0, 0);

    // async reset mid-operation
    step(1, 10'h011, 0);
    step(1, 10'h022, 0);
    step(1, 10'h033, 1);
    step(0, '0, 1);
    step(1, 10'h044, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #1;
    rst_n = 1'b1;
    step(1, 10'h155, 0);
    step(0, '0, 1);
    step(0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
